// File: rtl/glip_loopback_engine_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// glip_loopback_engine_if
// Streaming handshake bundle between the host and the loopback engine.
//
//   in_data   [WORD_WIDTH]  host -> engine word
//   in_valid                in_data is valid
//   in_ready                engine accepts in_data this cycle
//   out_data  [WORD_WIDTH]  engine -> host word
//   out_valid               out_data is valid
//   out_ready               host accepts out_data this cycle
//
// Modports:
//   master : the host side (drives in_*, out_ready)
//   slave  : the engine side (drives in_ready, out_data, out_valid)
// ---------------------------------------------------------------------------
interface glip_loopback_engine_if #(
    parameter int WORD_WIDTH = 16
) ();
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/glip_loopback_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// glip_loopback_engine
// Host-link test engine with four operating modes:
//   0 loopback           : words are buffered and returned unchanged
//   1 inverted loopback  : words are buffered and returned bit-inverted
//   2 generator          : emits an incrementing counter, input discarded
//   3 checker            : compares input against an incrementing counter,
//                          counts mismatches and resynchronises on error
//
// Ports:
//   clk         single clock
//   rst_n       asynchronous active-low reset
//   mode[1:0]   requested mode (registered internally)
//   clr_err     synchronous clear of err_cnt / err_flag (wins over increment)
//   bus         handshake bundle (slave modport)
//   fill_level  words held in the loopback buffer (0 in modes 2/3)
//   err_cnt     saturating checker mismatch count
//   err_flag    sticky mismatch indicator
//
// Control flow: after reset the engine sits in ST_INIT until the first clock
// edge, which loads the requested mode without flushing. Any later change of
// the requested mode loads the new mode and spends exactly one cycle in
// ST_FLUSH with both handshakes closed; the buffer and the gen/chk counters
// are cleared on the edge that enters ST_FLUSH.
// ---------------------------------------------------------------------------
module glip_loopback_engine #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    mode,
    input  logic                          clr_err,
    glip_loopback_engine_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [ERR_WIDTH-1:0]          err_cnt,
    output logic                          err_flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] MODE_LOOP = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_GEN  = 2'd2;
    localparam logic [1:0] MODE_CHK  = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [1:0]             mode_q,     mode_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic [WORD_WIDTH-1:0]  gen_q,      gen_d;
    logic [WORD_WIDTH-1:0]  chk_q,      chk_d;
    logic [ERR_WIDTH-1:0]   err_cnt_q,  err_cnt_d;
    logic                   err_flag_q, err_flag_d;

    // Loopback storage. Read is combinational so a word written on edge N
    // is at the head (and on out_data) right after edge N.
    logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake outputs and fire strobes
    // ------------------------------------------------------------------
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   in_ready_c;
    logic                   out_valid_c;
    logic [WORD_WIDTH-1:0]  out_data_c;
    logic                   push;
    logic                   pop;
    logic                   gen_fire;
    logic                   chk_fire;
    logic [WORD_WIDTH-1:0]  push_word;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        // Both handshakes stay closed in ST_INIT and ST_FLUSH.
        if (state_q == ST_RUN) begin
            case (mode_q)
                MODE_LOOP, MODE_INV: begin
                    // No bypass when full: a simultaneous pop does not
                    // open in_ready in the same cycle.
                    in_ready_c  = ~fifo_full;
                    out_valid_c = ~fifo_empty;
                    // Mask the head when empty so stale buffer contents
                    // never reach the output pins.
                    if (!fifo_empty) begin
                        out_data_c = mem[rd_ptr_q];
                    end
                end
                MODE_GEN: begin
                    in_ready_c  = 1'b1;
                    out_valid_c = 1'b1;
                    out_data_c  = gen_q;
                end
                default: begin
                    in_ready_c  = 1'b1;
                end
            endcase
        end
    end

    assign push      = in_ready_c  & bus.in_valid  & ~mode_q[1];
    assign pop       = out_valid_c & bus.out_ready & ~mode_q[1];
    assign gen_fire  = out_valid_c & bus.out_ready & (mode_q == MODE_GEN);
    assign chk_fire  = in_ready_c  & bus.in_valid  & (mode_q == MODE_CHK);
    assign push_word = (mode_q == MODE_INV) ? ~bus.in_data : bus.in_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        gen_d      = gen_q;
        chk_d      = chk_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;

        // Buffer bookkeeping; pointers wrap naturally (power-of-two depth).
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (gen_fire) begin
            gen_d = gen_q + 1'b1;
        end

        if (chk_fire) begin
            if (bus.in_data == chk_q) begin
                chk_d = chk_q + 1'b1;
            end else begin
                // Resync to the received stream so one dropped word costs
                // one error, not an error on every following word.
                chk_d      = bus.in_data + 1'b1;
                err_flag_d = 1'b1;
                if (err_cnt_q != {ERR_WIDTH{1'b1}}) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end

        if (clr_err) begin
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                // First edge out of reset: adopt the requested mode directly.
                mode_d  = mode;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                if (mode != mode_q) begin
                    // Mode change overrides any buffer/counter update from
                    // this edge; error statistics are left untouched.
                    mode_d   = mode;
                    state_d  = ST_FLUSH;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    gen_d    = '0;
                    chk_d    = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            mode_q     <= MODE_LOOP;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gen_q      <= '0;
            chk_q      <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gen_q      <= gen_d;
            chk_q      <= chk_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q and the
    // output is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign fill_level    = mode_q[1] ? '0 : count_q;
    assign err_cnt       = err_cnt_q;
    assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_glip_loopback_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_glip_loopback_engine
// Directed scenarios plus a randomized phase, all checked every cycle
// against a queue-based behavioural model of the engine.
// ---------------------------------------------------------------------------
module tb_glip_loopback_engine;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int EW = 16;
    localparam int FW = $clog2(D) + 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    mode    = 2'd0;
    logic          clr_err = 1'b0;
    logic [FW-1:0] fill_level;
    logic [EW-1:0] err_cnt;
    logic          err_flag;

    glip_loopback_engine_if #(.WORD_WIDTH(W)) bus_if ();

    glip_loopback_engine #(
        .WORD_WIDTH (W),
        .FIFO_DEPTH (D),
        .ERR_WIDTH  (EW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .clr_err    (clr_err),
        .bus        (bus_if),
        .fill_level (fill_level),
        .err_cnt    (err_cnt),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_q[$];
    int            m_mode;
    bit            m_started;
    bit            m_flush;
    logic [W-1:0]  m_gen;
    logic [W-1:0]  m_chk;
    logic [EW-1:0] m_err;
    bit            m_flag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_mode    = 0;
        m_started = 0;
        m_flush   = 0;
        m_gen     = '0;
        m_chk     = '0;
        m_err     = '0;
        m_flag    = 0;
    endfunction

    // What the engine should present during the current cycle.
    function automatic void model_out(output bit ir, output bit ov,
                                      output logic [W-1:0] od, output int fl);
        ir = 0; ov = 0; od = '0; fl = 0;
        if (m_started && !m_flush) begin
            if (m_mode < 2) begin
                ir = (m_q.size() < D);
                ov = (m_q.size() != 0);
                if (ov) od = m_q[0];
                fl = m_q.size();
            end else if (m_mode == 2) begin
                ir = 1; ov = 1; od = m_gen;
            end else begin
                ir = 1;
            end
        end
    endfunction

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        bit ir, ov;
        logic [W-1:0] od;
        int fl;
        if (!rst_n) return;
        model_out(ir, ov, od, fl);
        if (ir && bus_if.in_valid) begin
            if (m_mode == 0) m_q.push_back(bus_if.in_data);
            else if (m_mode == 1) m_q.push_back(~bus_if.in_data);
            else if (m_mode == 3) begin
                if (bus_if.in_data == m_chk) m_chk = m_chk + 1'b1;
                else begin
                    m_flag = 1;
                    if (m_err != '1) m_err = m_err + 1'b1;
                    m_chk = bus_if.in_data + 1'b1;
                end
            end
        end
        if (ov && bus_if.out_ready) begin
            if (m_mode < 2) void'(m_q.pop_front());
            else m_gen = m_gen + 1'b1;
        end
        if (clr_err) begin
            m_err  = '0;
            m_flag = 0;
        end
        if (!m_started) begin
            m_started = 1;
            m_mode    = int'(mode);
        end else begin
            m_flush = 0;
            if (int'(mode) != m_mode) begin
                m_mode  = int'(mode);
                m_flush = 1;
                m_q.delete();
                m_gen = '0;
                m_chk = '0;
            end
        end
    endtask

    task automatic compare_all();
        bit ir, ov;
        logic [W-1:0] od;
        int fl;
        model_out(ir, ov, od, fl);
        check_eq("in_ready",   32'(bus_if.in_ready),  32'(ir));
        check_eq("out_valid",  32'(bus_if.out_valid), 32'(ov));
        if (ov) check_eq("out_data", 32'(bus_if.out_data), 32'(od));
        check_eq("fill_level", 32'(fill_level), 32'(fl));
        check_eq("err_cnt",    32'(err_cnt),    32'(m_err));
        check_eq("err_flag",   32'(err_flag),   32'(m_flag));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy);
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.out_ready = ordy;
    endtask

    initial begin
        model_reset();
        drive(0, '0, 0);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        compare_all();
        check_eq("rst_out_data", 32'(bus_if.out_data), 32'h0);
        rst_n = 1'b1;
        cycle();
        $display("scenario reset/release done");

        // ---- fill to full, then drain in order ----
        for (int i = 1; i <= 16; i++) begin
            drive(1, W'(i), 0);
            cycle();
        end
        drive(0, '0, 0);
        check_eq("full_fill",     32'(fill_level), 32'd16);
        check_eq("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        drive(0, '0, 1);
        for (int i = 1; i <= 16; i++) begin
            check_eq("drain_data", 32'(bus_if.out_data), 32'(i));
            cycle();
        end
        check_eq("drained_fill", 32'(fill_level), 32'd0);
        $display("scenario fill/drain done");

        // ---- inverted loopback ----
        mode = 2'd1;
        drive(0, '0, 0);
        cycle();
        cycle();
        drive(1, 16'h00FF, 0);
        cycle();
        drive(0, '0, 0);
        check_eq("inv_valid", 32'(bus_if.out_valid), 32'd1);
        check_eq("inv_data",  32'(bus_if.out_data),  32'h0000FF00);
        drive(0, '0, 1);
        cycle();
        $display("scenario inverted loopback done");

        // ---- mode switch flush with data buffered ----
        mode = 2'd0;
        drive(0, '0, 0);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, W'($urandom), 0);
            cycle();
        end
        drive(0, '0, 0);
        check_eq("pre_flush_fill", 32'(fill_level), 32'd5);
        mode = 2'd2;
        cycle();
        check_eq("flush_in_ready",  32'(bus_if.in_ready),  32'd0);
        check_eq("flush_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("flush_fill",      32'(fill_level),       32'd0);
        cycle();
        check_eq("gen_first_valid", 32'(bus_if.out_valid), 32'd1);
        check_eq("gen_first_data",  32'(bus_if.out_data),  32'd0);
        $display("scenario mode-switch flush done");

        // ---- generator full wrap ----
        drive(0, '0, 1);
        for (int i = 0; i < 65538; i++) begin
            if (i >= 65535) check_eq("gen_wrap", 32'(bus_if.out_data), 32'(i & 32'hFFFF));
            cycle();
        end
        check_eq("gen_after_wrap", 32'(bus_if.out_data), 32'd2);
        $display("scenario generator wrap done");

        // ---- checker ----
        mode = 2'd3;
        drive(0, '0, 0);
        cycle();
        cycle();
        begin
            logic [W-1:0] seq [6];
            seq = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd9};
            foreach (seq[k]) begin
                drive(1, seq[k], 0);
                cycle();
            end
        end
        check_eq("chk_err_cnt",  32'(err_cnt),  32'd1);
        check_eq("chk_err_flag", 32'(err_flag), 32'd1);
        drive(1, 16'd5, 0);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        drive(0, '0, 0);
        check_eq("clr_err_cnt",  32'(err_cnt),  32'd0);
        check_eq("clr_err_flag", 32'(err_flag), 32'd0);
        $display("scenario checker done");

        // ---- reset mid-stream ----
        mode = 2'd0;
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, W'(16'h1000 + i), 0);
            cycle();
        end
        drive(0, '0, 0);
        check_eq("pre_rst_fill", 32'(fill_level), 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_in_ready",  32'(bus_if.in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(bus_if.out_data),  32'd0);
        check_eq("rst_fill",      32'(fill_level),       32'd0);
        cycle();
        rst_n = 1'b1;
        drive(0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("post_rst_valid", 32'(bus_if.out_valid), 32'd0);
        end
        drive(1, 16'hABCD, 1);
        cycle();
        drive(0, '0, 1);
        check_eq("post_rst_new", 32'(bus_if.out_data), 32'h0000ABCD);
        cycle();
        $display("scenario reset mid-stream done");

        // ---- first edge after release loads mode without flush ----
        #2;
        rst_n = 1'b0;
        model_reset();
        mode = 2'd2;
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("init_gen_valid", 32'(bus_if.out_valid), 32'd1);
        check_eq("init_gen_ready", 32'(bus_if.in_ready),  32'd1);
        check_eq("init_gen_data",  32'(bus_if.out_data),  32'd0);
        $display("scenario reset-to-generator done");

        // ---- randomized traffic ----
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            clr_err = ($urandom_range(0, 49) == 0);
            if (m_mode == 3 && $urandom_range(0, 3) != 0)
                drive($urandom_range(0, 1) == 1, m_chk, $urandom_range(0, 1) == 1);
            else
                drive($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) != 0);
            cycle();
        end
        clr_err = 1'b0;
        $display("scenario random traffic done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glip_loopback_engine.md
GLIP_LOOPBACK_ENGINE -- requirements
Module: glip_loopback_engine

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data word width in bits (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, loopback buffer depth in words (power of two, >=2).
REQ-003 SHALL have parameter ERR_WIDTH, default 16, width of error counter.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mode  input  2  0=loopback, 1=inverted loopback, 2=generator, 3=checker.
REQ-007 clr_err  input  1  synchronous clear of err_cnt and err_flag.
REQ-008 in_data  input  WORD_WIDTH  host-to-logic word.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  engine accepts in_data this cycle.
REQ-011 out_data  output  WORD_WIDTH  logic-to-host word.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  host accepts out_data this cycle.
REQ-014 fill_level  output  clog2(FIFO_DEPTH)+1  words held in buffer.
REQ-015 err_cnt  output  ERR_WIDTH  checker mismatch count.
REQ-016 err_flag  output  1  sticky: at least one mismatch since last clear.

Function
REQ-017 Handshake SHALL complete on a rising clk edge with valid and ready both high; out_data/out_valid SHALL stay stable until accepted.
REQ-018 Mode SHALL be registered; change of registered mode SHALL cause exactly one flush cycle: buffer emptied, gen/chk counters set to 0, in_ready=0, out_valid=0; err_cnt/err_flag retained.
REQ-019 Modes 0/1: word SHALL be pushed on input handshake (mode 1 stores bitwise inverse); out_valid=(fill_level!=0); out_data=head of buffer.
REQ-020 Modes 0/1: in_ready SHALL equal (fill_level!=FIFO_DEPTH); no full-state bypass, even with simultaneous pop.
REQ-021 Modes 0/1: minimum latency SHALL be 1 cycle (word accepted at edge N is visible on out_data after edge N).
REQ-022 Simultaneous push and pop SHALL leave fill_level unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Mode 2: in_ready=1 (input discarded), out_valid=1, out_data=gen counter; counter SHALL increment on output handshake and wrap 2^WORD_WIDTH-1 -> 0.
REQ-024 Mode 3: in_ready=1, out_valid=0; each accepted word SHALL be compared with chk counter.
REQ-025 Mode 3 match: chk counter <= chk+1; mismatch: err_cnt+1 (saturating at 2^ERR_WIDTH-1), err_flag<=1, chk counter <= in_data+1 (resync).
REQ-026 clr_err SHALL take priority over simultaneous mismatch increment (result: err_cnt=0, err_flag=0).
REQ-027 In modes 2/3, fill_level SHALL read 0.

Reset
REQ-028 rst_n low SHALL asynchronously force: buffer empty, pointers 0, gen/chk counters 0, err_cnt 0, err_flag 0, registered mode 0, in_ready 0, out_valid 0, out_data 0, fill_level 0.
REQ-029 First edge after rst_n release SHALL load registered mode from mode without a flush cycle; in_ready SHALL follow the mode rules from that cycle on.
REQ-030 Reset mid-transfer SHALL discard all buffered words; no word accepted before reset SHALL appear afterward.

Verification
REQ-031 Mode 0, DEPTH 16, out_ready=0, push 0x0001..0x0010 -> in_ready drops after 16th word, fill_level=16; then out_ready=1 -> 0x0001..0x0010 in order, fill_level 0.
REQ-032 Mode 1, push 0x00FF -> out_data 0xFF00 one cycle later.
REQ-033 Mode 2, out_ready=1 for 65538 cycles (W=16) -> 0x0000..0xFFFF, 0x0000, 0x0001.
REQ-034 Mode 3, input 0,1,2,7,8,9 -> err_cnt=1, err_flag=1; clr_err same cycle as next mismatch -> err_cnt=0, err_flag=0.
REQ-035 Mode 0 with 5 words buffered, switch to mode 2 -> one cycle in_ready=0/out_valid=0, fill_level 0, out_data starts at 0x0000.
REQ-036 rst_n low mid-stream with 3 words buffered -> outputs at reset values immediately; after release out_valid stays 0 until new input.
